mcu_traffic_gen: RTL and testbench

Synthesizable, parametrised traffic generator and checker for the random-request port of `ddr_memory_controler`. It replaces the hand-scheduled testbench stimulus with a self-running sequence: write a pattern over an address window, read the same window back, and compare the readback. It also drives `refresh_strobe` on a programmable period. It sits beside the MCU in simulation and on FPGA bring-up builds, and reports pass/fail plus error statistics.

---
 rtl/mcu_tg_pkg.sv | 43 ++++
 rtl/mcu_tg_checker.sv | 65 ++++++
 rtl/mcu_traffic_gen.sv | 165 ++++++++++++++++
 tb/tb_mcu_traffic_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_tg_pkg.sv
// Shared types and pattern helpers for the MCU random-port traffic generator.
package mcu_tg_pkg;

    localparam int unsigned TG_MAX_W = 128;
    localparam int unsigned LFSR_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SWITCH,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } tg_state_e;

    localparam logic [1:0] TG_INC  = 2'd0;
    localparam logic [1:0] TG_INV  = 2'd1;
    localparam logic [1:0] TG_LFSR = 2'd2;
    localparam logic [1:0] TG_WALK = 2'd3;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 32'd1;

    // Fibonacci LFSR, polynomial x^32 + x^22 + x^2 + x + 1
    function automatic logic [LFSR_W-1:0] tg_lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Data word for a given index; callers truncate to their data width
    function automatic logic [TG_MAX_W-1:0] tg_pattern(input logic [1:0]          mode,
                                                        input logic [TG_MAX_W-1:0] idx,
                                                        input logic [LFSR_W-1:0]   lfsr,
                                                        input int unsigned         data_w);
        logic [TG_MAX_W-1:0] res;
        case (mode)
            TG_INC:  res = idx;
            TG_INV:  res = ~idx;
            TG_LFSR: res = TG_MAX_W'(lfsr);
            default: res = TG_MAX_W'(1) << (idx % TG_MAX_W'(data_w));
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mcu_tg_checker.sv
// Read-data checker: delays expected values by READ_LAT and counts mismatches.
module mcu_tg_checker
    import mcu_tg_pkg::*;
#(
    parameter int unsigned ADDR_W   = 26,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 4
) (
    input  logic              CLK_n,
    input  logic              RST,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_exp,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              idle,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic [READ_LAT-1:0] vld;
    logic [DATA_W-1:0]   exp_q [READ_LAT];
    logic [ADDR_W-1:0]   adr_q [READ_LAT];
    logic                mism_c;

    assign mism_c = vld[READ_LAT-1] && (rd_data != exp_q[READ_LAT-1]);

    // Payload shift, no reset needed: only vld qualifies it
    always_ff @(posedge CLK_n) begin
        for (int i = READ_LAT - 1; i > 0; i--) begin
            exp_q[i] <= exp_q[i-1];
            adr_q[i] <= adr_q[i-1];
        end
        exp_q[0] <= push_exp;
        adr_q[0] <= push_addr;
    end

    // idle lags by one cycle so DRAIN exits after the last compare has settled
    always_ff @(posedge CLK_n) begin
        if (!RST) begin
            vld            <= '0;
            idle           <= 1'b1;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            for (int i = READ_LAT - 1; i > 0; i--) begin
                vld[i] <= vld[i-1];
            end
            vld[0] <= push;
            idle   <= !push && (vld == '0);
            if (clear) begin
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (mism_c) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == 16'd0) begin
                    first_err_addr <= adr_q[READ_LAT-1];
                end
            end
        end
    end

endmodule

// File: rtl/mcu_traffic_gen.sv
// Self-running write/read-back traffic generator for the MCU random-request port.
module mcu_traffic_gen
    import mcu_tg_pkg::*;
#(
    parameter int unsigned ADDR_W         = 26,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned N_WORDS        = 64,
    parameter int unsigned READ_LAT       = 4,
    parameter int unsigned REFRESH_PERIOD = 0
) (
    input  logic                CLK_n,
    input  logic                RST,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [1:0]          mode,
    output logic                rand_req,
    output logic                rand_req_we,
    output logic [DATA_W/8-1:0] rand_req_we_array,
    output logic [ADDR_W-1:0]   rand_req_address,
    output logic [DATA_W-1:0]   rand_req_datain,
    input  logic                rand_req_ack,
    input  logic [DATA_W-1:0]   user_req_dataout,
    output logic                refresh_strobe,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);

    localparam int unsigned RC_W     = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);
    localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(REFRESH_PERIOD - 1);
    localparam bit                REF_EN   = (REFRESH_PERIOD != 0);

    tg_state_e           state, state_d;
    logic [ADDR_W-1:0]   index, index_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          mode_q, mode_d;
    logic [LFSR_W-1:0]   wr_lfsr, wr_lfsr_d, rd_lfsr, rd_lfsr_d;
    logic                clear_c, xfer_c, push_c, chk_idle;
    logic [DATA_W-1:0]   exp_c;
    logic [RC_W-1:0]     ref_cnt;

    assign xfer_c = rand_req && rand_req_ack;
    assign push_c = xfer_c && (state == ST_READ);
    assign exp_c  = DATA_W'(tg_pattern(mode_q, TG_MAX_W'(index), rd_lfsr, DATA_W));

    // Next-state, index and pattern-generator advance
    always_comb begin
        state_d   = state;
        index_d   = index;
        base_d    = base_q;
        mode_d    = mode_q;
        wr_lfsr_d = wr_lfsr;
        rd_lfsr_d = rd_lfsr;
        clear_c   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_WRITE;
                    index_d   = '0;
                    base_d    = base_addr;
                    mode_d    = mode;
                    wr_lfsr_d = LFSR_SEED;
                    rd_lfsr_d = LFSR_SEED;
                    clear_c   = 1'b1;
                end
            end
            ST_WRITE: begin
                if (xfer_c) begin
                    wr_lfsr_d = tg_lfsr_next(wr_lfsr);
                    if (index == LAST_IDX) begin
                        state_d = ST_SWITCH;
                        index_d = '0;
                    end else begin
                        index_d = index + ADDR_W'(1);
                    end
                end
            end
            ST_SWITCH: state_d = ST_READ;
            ST_READ: begin
                if (xfer_c) begin
                    rd_lfsr_d = tg_lfsr_next(rd_lfsr);
                    if (index == LAST_IDX) begin
                        state_d = ST_DRAIN;
                        index_d = '0;
                    end else begin
                        index_d = index + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (chk_idle) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered request/status outputs
    always_ff @(posedge CLK_n) begin
        if (!RST) begin
            state             <= ST_IDLE;
            index             <= '0;
            base_q            <= '0;
            mode_q            <= TG_INC;
            wr_lfsr           <= LFSR_SEED;
            rd_lfsr           <= LFSR_SEED;
            rand_req          <= 1'b0;
            rand_req_we       <= 1'b0;
            rand_req_we_array <= '1;
            rand_req_address  <= '0;
            rand_req_datain   <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            pass              <= 1'b0;
        end else begin
            state             <= state_d;
            index             <= index_d;
            base_q            <= base_d;
            mode_q            <= mode_d;
            wr_lfsr           <= wr_lfsr_d;
            rd_lfsr           <= rd_lfsr_d;
            rand_req          <= (state_d == ST_WRITE) || (state_d == ST_READ);
            rand_req_we       <= (state_d == ST_WRITE);
            rand_req_we_array <= '1;
            rand_req_address  <= base_d + index_d;
            rand_req_datain   <= DATA_W'(tg_pattern(mode_d, TG_MAX_W'(index_d), wr_lfsr_d, DATA_W));
            busy              <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done              <= (state_d == ST_DONE);
            pass              <= (state_d == ST_DONE) && (err_count == 16'd0);
        end
    end

    // Refresh strobe runs regardless of the traffic state
    always_ff @(posedge CLK_n) begin
        if (!RST) begin
            ref_cnt        <= '0;
            refresh_strobe <= 1'b0;
        end else if (REF_EN && (ref_cnt == RC_LAST)) begin
            ref_cnt        <= '0;
            refresh_strobe <= !refresh_strobe;
        end else begin
            ref_cnt        <= ref_cnt + RC_W'(1);
        end
    end

    mcu_tg_checker #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_checker (
        .CLK_n          (CLK_n),
        .RST            (RST),
        .clear          (clear_c),
        .push           (push_c),
        .push_exp       (exp_c),
        .push_addr      (rand_req_address),
        .rd_data        (user_req_dataout),
        .idle           (chk_idle),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_mcu_traffic_gen.sv
// Scoreboard bench for mcu_traffic_gen against a bench-side memory with READ_LAT delay.
module tb_mcu_traffic_gen;

    localparam int unsigned ADDR_W   = 26;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned N_WORDS  = 16;
    localparam int unsigned READ_LAT = 4;
    localparam int unsigned REF_P    = 20;

    logic                CLK_n = 1'b0;
    logic                RST   = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [1:0]          mode = 2'd0;
    logic                rand_req, rand_req_we;
    logic [DATA_W/8-1:0] rand_req_we_array;
    logic [ADDR_W-1:0]   rand_req_address;
    logic [DATA_W-1:0]   rand_req_datain;
    logic                rand_req_ack = 1'b1;
    logic [DATA_W-1:0]   user_req_dataout;
    logic                refresh_strobe, busy, done, pass;
    logic [15:0]         err_count;
    logic [ADDR_W-1:0]   first_err_addr;

    mcu_traffic_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_WORDS(N_WORDS),
        .READ_LAT(READ_LAT), .REFRESH_PERIOD(REF_P)
    ) dut (
        .CLK_n(CLK_n), .RST(RST), .start(start), .base_addr(base_addr), .mode(mode),
        .rand_req(rand_req), .rand_req_we(rand_req_we), .rand_req_we_array(rand_req_we_array),
        .rand_req_address(rand_req_address), .rand_req_datain(rand_req_datain),
        .rand_req_ack(rand_req_ack), .user_req_dataout(user_req_dataout),
        .refresh_strobe(refresh_strobe), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 CLK_n = ~CLK_n;

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } xfer_t;

    int    tests = 0;
    int    fails = 0;
    xfer_t exp_q[$];
    xfer_t mon_e;
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] rd_pipe [READ_LAT];
    bit    ack_toggle = 0;
    bit    corrupt5   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & 32'h8020_0003)};
    endfunction

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] md, input int i, input logic [31:0] lf);
        case (md)
            2'd0:    return DATA_W'(i);
            2'd1:    return ~DATA_W'(i);
            2'd2:    return lf;
            default: return DATA_W'(1) << (i % 32);
        endcase
    endfunction

    // Memory model: writes land immediately, reads return READ_LAT edges later
    assign user_req_dataout = rd_pipe[READ_LAT-1];
    always @(posedge CLK_n) begin
        for (int i = READ_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= '0;
        if (RST && rand_req && rand_req_ack) begin
            if (rand_req_we)
                mem[rand_req_address] = rand_req_datain ^
                    DATA_W'(corrupt5 && (rand_req_address == ADDR_W'(5)));
            else
                rd_pipe[0] <= mem.exists(rand_req_address) ? mem[rand_req_address] : '1;
        end
    end

    always @(posedge CLK_n) begin
        #1;
        rand_req_ack = ack_toggle ? !rand_req_ack : 1'b1;
    end

    // Monitor: every accepted transfer is popped from the scoreboard and compared
    always @(negedge CLK_n) begin
        if (RST && rand_req && rand_req_ack) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_xfer: got addr %0h, expected no transfer", rand_req_address);
            end else begin
                mon_e = exp_q.pop_front();
                chk("xfer_we", 64'(rand_req_we), 64'(mon_e.we));
                chk("xfer_addr", 64'(rand_req_address), 64'(mon_e.addr));
                if (mon_e.we) chk("xfer_wdata", 64'(rand_req_datain), 64'(mon_e.data));
            end
        end
    end

    // Refresh monitor: every toggle must come exactly REF_P edges after the last one or reset
    int cyc = 0;
    int ref_cyc = 0;
    int n_tog = 0;
    bit rst_edge = 1;
    logic prev_str = 1'b0;
    always @(posedge CLK_n) begin
        cyc      <= cyc + 1;
        rst_edge <= !RST;
    end
    always @(negedge CLK_n) begin
        if (rst_edge) begin
            ref_cyc  = cyc;
            prev_str = 1'b0;
        end else if (refresh_strobe !== prev_str) begin
            chk("refresh_gap", 64'(cyc - ref_cyc), 64'(REF_P));
            ref_cyc  = cyc;
            prev_str = refresh_strobe;
            n_tog++;
        end else if (cyc - ref_cyc == int'(REF_P) + 1) begin
            tests++;
            fails++;
            $display("FAIL refresh_late: got no toggle after %0d edges, expected %0d", REF_P + 1, REF_P);
        end
    end

    task automatic push_run(input logic [ADDR_W-1:0] base, input logic [1:0] md);
        logic [31:0] lf;
        lf = 32'd1;
        for (int i = 0; i < int'(N_WORDS); i++) begin
            exp_q.push_back('{1'b1, base + ADDR_W'(i), pat(md, i, lf)});
            lf = lfsr_step(lf);
        end
        for (int i = 0; i < int'(N_WORDS); i++)
            exp_q.push_back('{1'b0, base + ADDR_W'(i), '0});
    endtask

    task automatic start_run(input logic [ADDR_W-1:0] base, input logic [1:0] md);
        @(posedge CLK_n); #1;
        start = 1'b1; base_addr = base; mode = md;
        @(posedge CLK_n); #1;
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_req", 64'(rand_req), 64'(1));
        chk("start_done_clr", 64'(done), 64'(0));
        chk("start_pass_clr", 64'(pass), 64'(0));
        chk("start_err_clr", 64'(err_count), 64'(0));
        chk("start_first_clr", 64'(first_err_addr), 64'(0));
    endtask

    task automatic run(input logic [ADDR_W-1:0] base, input logic [1:0] md, input int exp_err,
                       input logic [ADDR_W-1:0] exp_first, input int exp_edge);
        int k;
        push_run(base, md);
        start_run(base, md);
        k = 0;
        while (done !== 1'b1 && k < 2000) begin
            @(posedge CLK_n); #1;
            k++;
        end
        if (done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL run_timeout: got done=%b after %0d edges, expected 1", done, k);
        end else begin
            if (exp_edge > 0) chk("done_edge", 64'(k), 64'(exp_edge));
            chk("run_pass", 64'(pass), 64'(exp_err == 0));
            chk("run_err_count", 64'(err_count), 64'(exp_err));
            chk("run_first_err", 64'(first_err_addr), 64'(exp_first));
            chk("run_busy_low", 64'(busy), 64'(0));
            chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        end
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge CLK_n);
        @(negedge CLK_n);
        chk("rst_req", 64'(rand_req), 64'(0));
        chk("rst_we", 64'(rand_req_we), 64'(0));
        chk("rst_we_array", 64'(rand_req_we_array), 64'(4'hF));
        chk("rst_addr", 64'(rand_req_address), 64'(0));
        chk("rst_datain", 64'(rand_req_datain), 64'(0));
        chk("rst_refresh", 64'(refresh_strobe), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_pass", 64'(pass), 64'(0));
        chk("rst_err", 64'(err_count), 64'(0));
        chk("rst_first", 64'(first_err_addr), 64'(0));
        @(posedge CLK_n); #1;
        RST = 1'b1;

        // mode 0, ack high: done at 2*16 + 4 + 3 = edge 39
        run(26'd0, 2'd0, 0, 26'd0, 39);

        ack_toggle = 1;
        run(26'd0, 2'd0, 0, 26'd0, 0);
        ack_toggle = 0;

        corrupt5 = 1;
        run(26'd0, 2'd1, 1, 26'd5, 39);
        corrupt5 = 0;
        run(26'd0, 2'd1, 0, 26'd0, 39);

        run(26'h3FF_FFFC, 2'd3, 0, 26'd0, 39);
        run(26'd100, 2'd2, 0, 26'd0, 39);

        // Reset in the middle of the write phase
        push_run(26'd0, 2'd0);
        start_run(26'd0, 2'd0);
        repeat (5) @(posedge CLK_n);
        #1 RST = 1'b0;
        @(posedge CLK_n); #1;
        chk("midrst_req", 64'(rand_req), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_refresh", 64'(refresh_strobe), 64'(0));
        RST = 1'b1;
        exp_q.delete();
        run(26'd0, 2'd0, 0, 26'd0, 39);

        repeat (45) @(posedge CLK_n);
        chk("refresh_toggles_seen", 64'(n_tog >= 10), 64'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
        $fatal(1, "watchdog");
    end

endmodule
